// File: rtl/e_m_elastic_buffer_pkg.sv
// Shared types for the Execute->Memory elastic buffer: the E/M payload bundle.
// Width macros normally come from the global defines; fallbacks keep the slice self-contained.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

package e_m_elastic_buffer_pkg;

    localparam int unsigned WORD_SIZE     = `WORD_SIZE;
    localparam int unsigned INSTR_TYPE_SZ = `INSTR_TYPE_SZ;
    localparam int unsigned ROB_ID_W      = `ROB_ENTRY_WIDTH;

    typedef struct packed {
        logic [INSTR_TYPE_SZ-1:0] instruction_type;
        logic [WORD_SIZE-1:0]     pc;
        logic [2:0]               funct3;
        logic [WORD_SIZE-1:0]     aluResult;
        logic [WORD_SIZE-1:0]     s2;
        logic [ROB_ID_W-1:0]      rob_id;
    } e_m_payload_t;

    localparam int unsigned PAYLOAD_W = $bits(e_m_payload_t);

endpackage

// File: rtl/e_m_elastic_buffer_if.sv
// Execute->Memory handshake bundle; master drives Execute side and Memory ready, slave is the buffer.
interface e_m_elastic_buffer_if
    import e_m_elastic_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [INSTR_TYPE_SZ-1:0] instruction_type;
    logic [WORD_SIZE-1:0]     pc;
    logic [2:0]               funct3;
    logic [WORD_SIZE-1:0]     aluResult;
    logic [WORD_SIZE-1:0]     s2;
    logic [ROB_ID_W-1:0]      rob_id;

    logic                     out_valid;
    logic                     out_ready;
    logic [INSTR_TYPE_SZ-1:0] instruction_type_out;
    logic [WORD_SIZE-1:0]     pc_out;
    logic [2:0]               funct3_out;
    logic [WORD_SIZE-1:0]     aluResult_out;
    logic [WORD_SIZE-1:0]     s2_out;
    logic [ROB_ID_W-1:0]      rob_id_out;
    logic [OCC_W-1:0]         occupancy;

    modport master (
        output flush, in_valid, instruction_type, pc, funct3, aluResult, s2, rob_id, out_ready,
        input  in_ready, out_valid, instruction_type_out, pc_out, funct3_out,
               aluResult_out, s2_out, rob_id_out, occupancy
    );

    modport slave (
        input  flush, in_valid, instruction_type, pc, funct3, aluResult, s2, rob_id, out_ready,
        output in_ready, out_valid, instruction_type_out, pc_out, funct3_out,
               aluResult_out, s2_out, rob_id_out, occupancy
    );

endinterface

// File: rtl/e_m_elastic_buffer_sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with synchronous flush; DEPTH must be a power of two >= 2.
module sync_fifo_fwft #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // Ready depends only on registered count, so no combinational path from out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/e_m_elastic_buffer.sv
// Execute->Memory elastic buffer: packs the E/M bundle into a FWFT queue of DEPTH entries.
module e_m_elastic_buffer
    import e_m_elastic_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input logic                 clk,
    input logic                 reset,
    e_m_elastic_buffer_if.slave bus
);

    e_m_payload_t           in_pl;
    e_m_payload_t           out_pl;
    logic [$clog2(DEPTH):0] count;

    always_comb begin
        in_pl                  = '0;
        in_pl.instruction_type = bus.instruction_type;
        in_pl.pc               = bus.pc;
        in_pl.funct3           = bus.funct3;
        in_pl.aluResult        = bus.aluResult;
        in_pl.s2               = bus.s2;
        in_pl.rob_id           = bus.rob_id;
    end

    sync_fifo_fwft #(
        .DATA_W (PAYLOAD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_pl),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pl),
        .count     (count)
    );

    assign bus.instruction_type_out = out_pl.instruction_type;
    assign bus.pc_out               = out_pl.pc;
    assign bus.funct3_out           = out_pl.funct3;
    assign bus.aluResult_out        = out_pl.aluResult;
    assign bus.s2_out               = out_pl.s2;
    assign bus.rob_id_out           = out_pl.rob_id;
    assign bus.occupancy            = count;

endmodule

// File: tb/tb_e_m_elastic_buffer.sv
// Directed bench for e_m_elastic_buffer (DEPTH=2): vector table plus hand-written corner sequences.
module tb_e_m_elastic_buffer;
    import e_m_elastic_buffer_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    e_m_elastic_buffer_if #(.DEPTH(DEPTH)) bus ();

    e_m_elastic_buffer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        ev;
        logic        er;
        logic [1:0]  eo;
        logic [31:0] epc;
        logic        cp;
    } vec_t;

    vec_t vecs[$];

    // Payload derived from pc so one number identifies a whole entry; pc=0 yields all zeros.
    function automatic e_m_payload_t mk(input logic [31:0] p);
        e_m_payload_t r;
        r.instruction_type = p[INSTR_TYPE_SZ-1:0];
        r.pc               = WORD_SIZE'(p);
        r.funct3           = p[2:0];
        r.aluResult        = WORD_SIZE'(p * 3);
        r.s2               = WORD_SIZE'({p[15:0], p[31:16]});
        r.rob_id           = p[ROB_ID_W-1:0];
        return r;
    endfunction

    function automatic vec_t v(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                               input logic ordy, input logic ev, input logic er, input logic [1:0] eo,
                               input logic [31:0] epc, input logic cp);
        vec_t r;
        r.rst = rst; r.fl = fl; r.iv = iv; r.pc = pc; r.ordy = ordy;
        r.ev = ev; r.er = er; r.eo = eo; r.epc = epc; r.cp = cp;
        return r;
    endfunction

    function automatic e_m_payload_t head();
        e_m_payload_t r;
        r.instruction_type = bus.instruction_type_out;
        r.pc               = bus.pc_out;
        r.funct3           = bus.funct3_out;
        r.aluResult        = bus.aluResult_out;
        r.s2               = bus.s2_out;
        r.rob_id           = bus.rob_id_out;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input e_m_payload_t p, input logic ordy);
        bus.in_valid         = iv;
        bus.instruction_type = p.instruction_type;
        bus.pc               = p.pc;
        bus.funct3           = p.funct3;
        bus.aluResult        = p.aluResult;
        bus.s2               = p.s2;
        bus.rob_id           = p.rob_id;
        bus.out_ready        = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        e_m_payload_t p;
        string        tag;
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        bus.flush = 1'b0;
        drive(1'b0, '0, 1'b0);

        // Reset then idle
        tick();
        reset = 1'b0;
        chk("reset out_valid", 128'(bus.out_valid), 128'(1'b0));
        chk("reset in_ready",  128'(bus.in_ready),  128'(1'b1));
        chk("reset occupancy", 128'(bus.occupancy), 128'(0));
        chk("reset pc_out",    128'(bus.pc_out),    128'(0));
        chk("reset alu_out",   128'(bus.aluResult_out), 128'(0));

        // Single pass-through; no same-cycle bypass before the edge
        p = '0;
        p.pc = 1222; p.funct3 = 3'd3; p.aluResult = 7; p.s2 = 3; p.rob_id = 2;
        drive(1'b1, p, 1'b1);
        #1;
        chk("no bypass out_valid", 128'(bus.out_valid), 128'(1'b0));
        tick();
        drive(1'b0, '0, 1'b1);
        chk("pass out_valid", 128'(bus.out_valid),     128'(1'b1));
        chk("pass pc_out",    128'(bus.pc_out),        128'(1222));
        chk("pass rob_id",    128'(bus.rob_id_out),    128'(2));
        chk("pass funct3",    128'(bus.funct3_out),    128'(3));
        chk("pass aluResult", 128'(bus.aluResult_out), 128'(7));
        chk("pass s2",        128'(bus.s2_out),        128'(3));
        tick();
        chk("pass drained", 128'(bus.out_valid), 128'(1'b0));

        //            rst fl iv pc   ordy ev er eo epc cp
        vecs.push_back(v(1, 0, 0, 0,   0,  0, 1, 0, 0,   1));
        vecs.push_back(v(0, 0, 1, 100, 0,  1, 1, 1, 100, 1));
        vecs.push_back(v(0, 0, 1, 200, 0,  1, 0, 2, 100, 1));
        vecs.push_back(v(0, 0, 1, 300, 0,  1, 0, 2, 100, 1));
        vecs.push_back(v(0, 0, 1, 300, 1,  1, 1, 1, 200, 1));
        vecs.push_back(v(0, 0, 1, 300, 0,  1, 0, 2, 200, 1));
        vecs.push_back(v(0, 0, 0, 0,   1,  1, 1, 1, 300, 1));
        vecs.push_back(v(0, 0, 0, 0,   1,  0, 1, 0, 0,   0));
        vecs.push_back(v(0, 0, 1, 1,   1,  1, 1, 1, 1,   1));
        vecs.push_back(v(0, 0, 1, 2,   0,  1, 0, 2, 1,   1));
        vecs.push_back(v(0, 0, 1, 3,   1,  1, 1, 1, 2,   1));
        vecs.push_back(v(0, 0, 1, 3,   0,  1, 0, 2, 2,   1));
        vecs.push_back(v(0, 0, 1, 4,   1,  1, 1, 1, 3,   1));
        vecs.push_back(v(0, 0, 1, 4,   0,  1, 0, 2, 3,   1));
        vecs.push_back(v(0, 0, 1, 5,   1,  1, 1, 1, 4,   1));
        vecs.push_back(v(0, 0, 1, 5,   0,  1, 0, 2, 4,   1));
        vecs.push_back(v(0, 0, 0, 0,   1,  1, 1, 1, 5,   1));
        vecs.push_back(v(0, 0, 0, 0,   1,  0, 1, 0, 0,   0));
        vecs.push_back(v(0, 0, 1, 6,   1,  1, 1, 1, 6,   1));
        vecs.push_back(v(0, 0, 1, 7,   1,  1, 1, 1, 7,   1));
        vecs.push_back(v(0, 0, 1, 8,   1,  1, 1, 1, 8,   1));
        vecs.push_back(v(0, 0, 1, 9,   0,  1, 0, 2, 8,   1));
        vecs.push_back(v(0, 1, 1, 77,  0,  0, 1, 0, 0,   0));
        vecs.push_back(v(0, 0, 0, 0,   0,  0, 1, 0, 0,   0));
        vecs.push_back(v(0, 0, 1, 10,  0,  1, 1, 1, 10,  1));
        vecs.push_back(v(0, 0, 1, 11,  0,  1, 0, 2, 10,  1));
        vecs.push_back(v(1, 1, 1, 12,  1,  0, 1, 0, 0,   1));
        vecs.push_back(v(0, 0, 0, 0,   0,  0, 1, 0, 0,   1));

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            bus.flush = vecs[i].fl;
            drive(vecs[i].iv, mk(vecs[i].pc), vecs[i].ordy);
            tick();
            reset     = 1'b0;
            bus.flush = 1'b0;
            tag = $sformatf("vec%0d", i);
            chk({tag, " out_valid"}, 128'(bus.out_valid), 128'(vecs[i].ev));
            chk({tag, " in_ready"},  128'(bus.in_ready),  128'(vecs[i].er));
            chk({tag, " occupancy"}, 128'(bus.occupancy), 128'(vecs[i].eo));
            if (vecs[i].cp) begin
                chk({tag, " payload"}, 128'(head()), 128'(mk(vecs[i].epc)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/e_m_elastic_buffer.md
Name: e_m_elastic_buffer

Overview:
- Parametrised successor to the fixed Execute→Memory pipeline register.
- Replaces the single stall-gated register with a DEPTH-entry first-word-fall-through queue, using valid/ready handshakes on both sides, plus a flush input.
- Lets Execute keep issuing while Memory is stalled, for up to DEPTH instructions.
- Payload is the E/M bundle: instruction type, pc, funct3, ALU result, s2 and ROB id.

Parameters:
- WORD_SIZE, `WORD_SIZE: width of pc, aluResult and s2.
- INSTR_TYPE_SZ, `INSTR_TYPE_SZ: width of instruction_type.
- ROB_ID_W, `ROB_ENTRY_WIDTH: width of rob_id.
- DEPTH, 2: number of entries. Must be a power of two and at least 2.

Ports:
- clk  in  1  single clock; everything is updated on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all queued entries (branch mispredict or exception).
- in_valid  in  1  Execute presents a valid instruction.
- in_ready  out  1  buffer can accept an entry this cycle.
- instruction_type  in  INSTR_TYPE_SZ  payload field.
- pc  in  WORD_SIZE  payload field.
- funct3  in  3  payload field.
- aluResult  in  WORD_SIZE  payload field.
- s2  in  WORD_SIZE  payload field.
- rob_id  in  ROB_ID_W  payload field.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  Memory consumes the head entry (equal to !stall of the Memory stage).
- instruction_type_out, pc_out, funct3_out, aluResult_out, s2_out, rob_id_out  out  same widths as inputs  head-entry payload.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH payload entries.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register, 0..DEPTH.
- Combinational outputs (registered state only):
  - in_ready = (count != DEPTH). It has no dependence on out_ready, so there is no combinational ready path.
  - out_valid = (count != 0).
  - occupancy = count.
  - Payload outputs = entry[rd_ptr], first-word-fall-through.
- Transfers:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- On push: write entry[wr_ptr] and increment wr_ptr.
- On pop: increment rd_ptr.
- count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Latency: an entry pushed in cycle N is visible at the outputs, with out_valid=1, in cycle N+1 when the queue was empty. There is no same-cycle bypass.
- Full: in_ready=0, so a push is refused even if a pop happens the same cycle. in_ready rises the cycle after the pop.
- Empty: out_valid=0, and out_ready is ignored. Payload outputs show entry[rd_ptr] as stale data; consumers qualify with out_valid.
- Pointer wrap from DEPTH-1 to 0 must be seamless, with no bubble.
- Flush:
  - Takes effect at the clock edge where flush=1: count←0, wr_ptr←0, rd_ptr←0.
  - A same-cycle push is discarded and a same-cycle pop is irrelevant.
  - Payload storage is not cleared.
  - out_valid=0 and in_ready=1 from the next cycle.
- Reset:
  - Same effect as flush, and additionally clears every payload entry to 0.
  - Reset has priority over flush and over any transfer.
- Reset values:
  - out_valid=0, in_ready=1, occupancy=0.
  - All payload outputs 0.
- Reset asserted mid-operation discards all entries regardless of the handshake state in that cycle.
- Invalid entries are never popped. An in_valid=0 input consumes no slot.

Decomposition:
- Shared package: the e_m_payload_t packed struct (instruction_type, pc, funct3, aluResult, s2, rob_id).
  - Width constants WORD_SIZE, INSTR_TYPE_SZ and ROB_ENTRY_WIDTH already live in the global defines; the struct references them.
- One natural sub-module: sync_fifo_fwft, a generic first-word-fall-through FIFO parametrised by DATA_W and DEPTH with flush.
  - e_m_elastic_buffer packs and unpacks the struct around it and exposes occupancy.

Test Plan:
1. Reset then idle: reset=1 for 1 cycle → out_valid=0, in_ready=1, occupancy=0, pc_out=0, aluResult_out=0.
2. Single pass-through: push pc=1222, funct3=3, aluResult=7, s2=3, rob_id=2, with out_ready=1 → next cycle out_valid=1, pc_out=1222, rob_id_out=2. The cycle after, out_valid=0.
3. Stall fill, DEPTH=2: out_ready=0, push pc=100 then pc=200 → occupancy=2, in_ready=0. A third push of pc=300 is refused. Raise out_ready → pc_out=100 then 200, in order; pc=300 is never seen unless re-presented.
4. Full with simultaneous pop: full queue, out_ready=1, in_valid=1 with pc=300 → that cycle pops pc=100 and pushes nothing, occupancy=1. Next cycle in_ready=1 and pc=300 is accepted.
5. Wrap-around: stream 2·DEPTH+1 entries (pc=1..5 for DEPTH=2) with out_ready toggling 1,0,1,… → outputs appear in the order 1,2,3,4,5 with no loss or duplication.
6. Flush vs reset priority: queue holding 2 entries, flush=1 together with in_valid=1 (pc=77) → next cycle occupancy=0, out_valid=0, pc=77 is absent. Asserting reset=1 and flush=1 together gives the reset values, including all payload outputs 0.
